// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response engine.
package uart_cmd_pkg;

  // Responder FSM states.
  typedef enum logic [3:0] {
    StIdle,
    StGotCmd,
    StValidate,
    StReq,
    StWaitRsp,
    StSend0,
    StWait0,
    StSend1,
    StWait1
  } state_e;

  // Status bytes generated locally instead of by the application.
  localparam logic [7:0] ST_BAD_CMD  = 8'hFF;
  localparam logic [7:0] ST_BAD_ADDR = 8'hFE;
  localparam logic [7:0] ST_TIMEOUT  = 8'hFD;

  // Largest legal command and address bytes.
  localparam logic [7:0] CMD_MAX  = 8'h06;
  localparam logic [7:0] ADDR_MAX = 8'h1F;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Bundle of the UART-side and application-side signals of the responder.
interface uart_cmd_responder_if;

  // From uart_rx
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  // To/from uart_tx
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  // Application side
  logic       o_Req_Valid;
  logic [7:0] o_Req_Cmd;
  logic [4:0] o_Req_Addr;
  logic       i_Rsp_Valid;
  logic [7:0] i_Rsp_Code;
  logic [7:0] i_Rsp_Data;
  // Status
  logic       o_Busy;
  logic       o_Overrun;

  // Responder side.
  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Rsp_Valid, i_Rsp_Code, i_Rsp_Data,
    output o_Tx_DV, o_Tx_Byte, o_Req_Valid, o_Req_Cmd, o_Req_Addr, o_Busy, o_Overrun
  );

  // Environment side: UART pair plus application logic.
  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Rsp_Valid, i_Rsp_Code, i_Rsp_Data,
    input  o_Tx_DV, o_Tx_Byte, o_Req_Valid, o_Req_Cmd, o_Req_Addr, o_Busy, o_Overrun
  );

endinterface

// File: rtl/uart_cmd_responder_cycle_timer.sv
// Up-counting timeout timer: expires in the N-th enabled cycle after a clear.
module cycle_timer #(
  parameter int unsigned N = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned Width = $clog2(N + 1);
  localparam logic [Width-1:0] LastCount = Width'(N - 1);

  logic [Width-1:0] count_q, count_d;

  assign expired_o = enable_i && (count_q == LastCount);

  // Count enabled cycles; park at the last count once expired.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + Width'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Frames 2-byte requests from the UART, issues them to the application and
// returns a 2-byte (status, data) response through the UART transmitter.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT_CLKS = 520900,
  parameter int unsigned RSP_TIMEOUT_CLKS  = 50000000
) (
  input logic                 i_Clock,
  input logic                 i_Reset,
  uart_cmd_responder_if.slave resp_if
);

  state_e     state_q, state_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic [7:0] addr_byte_q, addr_byte_d;
  logic [7:0] status_q, status_d;
  logic [7:0] data_q, data_d;
  logic [7:0] req_cmd_q, req_cmd_d;
  logic [4:0] req_addr_q, req_addr_d;
  logic       overrun_q, overrun_d;

  logic cmd_bad, addr_bad;
  logic byte_clear, byte_enable, byte_expired;
  logic rsp_clear, rsp_enable, rsp_expired;

  assign cmd_bad  = cmd_byte_q > CMD_MAX;
  assign addr_bad = addr_byte_q > ADDR_MAX;

  // Timers are held clear outside their state so they start from zero on entry.
  assign byte_enable = (state_q == StGotCmd);
  assign byte_clear  = !byte_enable;
  assign rsp_enable  = (state_q == StWaitRsp);
  assign rsp_clear   = !rsp_enable;

  cycle_timer #(
    .N(BYTE_TIMEOUT_CLKS)
  ) u_byte_timer (
    .clk_i    (i_Clock),
    .rst_i    (i_Reset),
    .clear_i  (byte_clear),
    .enable_i (byte_enable),
    .expired_o(byte_expired)
  );

  cycle_timer #(
    .N(RSP_TIMEOUT_CLKS)
  ) u_rsp_timer (
    .clk_i    (i_Clock),
    .rst_i    (i_Reset),
    .clear_i  (rsp_clear),
    .enable_i (rsp_enable),
    .expired_o(rsp_expired)
  );

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte arriving in the expiry cycle still beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (resp_if.i_Rx_DV) state_d = StGotCmd;
      StGotCmd: begin
        if (resp_if.i_Rx_DV) begin
          state_d = StValidate;
        end else if (byte_expired) begin
          state_d = StIdle;
        end
      end
      StValidate: state_d = (cmd_bad || addr_bad) ? StSend0 : StReq;
      StReq:      state_d = StWaitRsp;
      StWaitRsp:  if (resp_if.i_Rsp_Valid || rsp_expired) state_d = StSend0;
      StSend0:    if (!resp_if.i_Tx_Active) state_d = StWait0;
      StWait0:    if (resp_if.i_Tx_Done) state_d = StSend1;
      StSend1:    if (!resp_if.i_Tx_Active) state_d = StWait1;
      StWait1:    if (resp_if.i_Tx_Done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath next-state: frame capture, validation, response load, overrun flag.
  always_comb begin
    cmd_byte_d  = cmd_byte_q;
    addr_byte_d = addr_byte_q;
    status_d    = status_q;
    data_d      = data_q;
    req_cmd_d   = req_cmd_q;
    req_addr_d  = req_addr_q;
    overrun_d   = overrun_q;

    if (state_q == StIdle && resp_if.i_Rx_DV) begin
      cmd_byte_d = resp_if.i_Rx_Byte;
    end
    if (state_q == StGotCmd && resp_if.i_Rx_DV) begin
      addr_byte_d = resp_if.i_Rx_Byte;
    end

    // Command check has priority over the address check.
    if (state_q == StValidate) begin
      if (cmd_bad) begin
        status_d = ST_BAD_CMD;
        data_d   = cmd_byte_q;
      end else if (addr_bad) begin
        status_d = ST_BAD_ADDR;
        data_d   = addr_byte_q;
      end else begin
        req_cmd_d  = cmd_byte_q;
        req_addr_d = addr_byte_q[4:0];
      end
    end

    // A response in the expiry cycle wins over the timeout.
    if (state_q == StWaitRsp) begin
      if (resp_if.i_Rsp_Valid) begin
        status_d = resp_if.i_Rsp_Code;
        data_d   = resp_if.i_Rsp_Data;
      end else if (rsp_expired) begin
        status_d = ST_TIMEOUT;
        data_d   = 8'h00;
      end
    end

    if (resp_if.i_Rx_DV && state_q != StIdle && state_q != StGotCmd) begin
      overrun_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cmd_byte_q  <= 8'h00;
      addr_byte_q <= 8'h00;
      status_q    <= 8'h00;
      data_q      <= 8'h00;
      req_cmd_q   <= 8'h00;
      req_addr_q  <= 5'd0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_byte_q  <= cmd_byte_d;
      addr_byte_q <= addr_byte_d;
      status_q    <= status_d;
      data_q      <= data_d;
      req_cmd_q   <= req_cmd_d;
      req_addr_q  <= req_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs: Tx byte is held from the start strobe until the matching done.
  always_comb begin
    resp_if.o_Tx_Byte = 8'h00;
    unique case (state_q)
      StSend0, StWait0: resp_if.o_Tx_Byte = status_q;
      StSend1, StWait1: resp_if.o_Tx_Byte = data_q;
      default:          resp_if.o_Tx_Byte = 8'h00;
    endcase
    resp_if.o_Tx_DV     = (state_q == StSend0 || state_q == StSend1) && !resp_if.i_Tx_Active;
    resp_if.o_Req_Valid = (state_q == StReq);
    resp_if.o_Req_Cmd   = req_cmd_q;
    resp_if.o_Req_Addr  = req_addr_q;
    resp_if.o_Busy      = (state_q != StIdle);
    resp_if.o_Overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with shortened timeouts.
module tb_uart_cmd_responder;

  localparam int unsigned ByteTo = 20;
  localparam int unsigned RspTo  = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_responder_if bus ();

  uart_cmd_responder #(
    .BYTE_TIMEOUT_CLKS(ByteTo),
    .RSP_TIMEOUT_CLKS (RspTo)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .resp_if(bus.slave)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;
  int unsigned n_dv    = 0;
  int unsigned n_req   = 0;

  // Cycle counter and strobe counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_Tx_DV) n_dv <= n_dv + 1;
    if (bus.o_Req_Valid) n_req <= n_req + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    next_cycle();
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic rsp(input logic [7:0] code, input logic [7:0] data);
    bus.i_Rsp_Valid = 1'b1;
    bus.i_Rsp_Code  = code;
    bus.i_Rsp_Data  = data;
    next_cycle();
    bus.i_Rsp_Valid = 1'b0;
  endtask

  // Send both request bytes and check the request strobe two cycles later.
  task automatic do_req(input string tag, input logic [7:0] c, input logic [7:0] a);
    rx_byte(c);
    rx_byte(a);
    next_cycle();
    @(negedge clk);
    check_eq({tag, " req"}, 32'(bus.o_Req_Valid), 32'd1);
    check_eq({tag, " cmd"}, 32'(bus.o_Req_Cmd), 32'(c));
    check_eq({tag, " addr"}, 32'(bus.o_Req_Addr), 32'(a));
    next_cycle();
  endtask

  // Wait (bounded) for o_Tx_DV; returns at its negedge with the cycle number.
  task automatic wait_tx(input string tag, input logic [7:0] exp, input int budget,
                         output int unsigned at);
    bit seen;
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_Tx_DV) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
      next_cycle();
    end
    check_eq({tag, " dv"}, 32'(seen), 32'd1);
    check_eq({tag, " byte"}, 32'(bus.o_Tx_Byte), 32'(exp));
  endtask

  // Play the transmitter: busy for a few cycles, then a done pulse.
  task automatic tx_finish(input string tag, input logic [7:0] exp, input int busy,
                           output int unsigned done_at);
    next_cycle();
    bus.i_Tx_Active = 1'b1;
    for (int i = 0; i < busy; i++) next_cycle();
    @(negedge clk);
    check_eq({tag, " hold"}, 32'(bus.o_Tx_Byte), 32'(exp));
    next_cycle();
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done   = 1'b1;
    done_at         = cyc;
    next_cycle();
    bus.i_Tx_Done   = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] st, input logic [7:0] dat,
                            input int budget, output int unsigned at0);
    int unsigned at1, d0, d1;
    wait_tx({tag, " st"}, st, budget, at0);
    tx_finish({tag, " st"}, st, 3, d0);
    wait_tx({tag, " dat"}, dat, 3, at1);
    check_eq({tag, " dat lat"}, at1, d0 + 1);
    tx_finish({tag, " dat"}, dat, 2, d1);
    @(negedge clk);
    check_eq({tag, " idle"}, 32'(bus.o_Busy), 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned at0, e, w, snap_dv, snap_req;
    bus.i_Rx_DV     = 1'b0;
    bus.i_Rx_Byte   = 8'h00;
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done   = 1'b0;
    bus.i_Rsp_Valid = 1'b0;
    bus.i_Rsp_Code  = 8'h00;
    bus.i_Rsp_Data  = 8'h00;

    // Reset values
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("rst tx_dv", 32'(bus.o_Tx_DV), 32'd0);
    check_eq("rst tx_byte", 32'(bus.o_Tx_Byte), 32'd0);
    check_eq("rst req_valid", 32'(bus.o_Req_Valid), 32'd0);
    check_eq("rst req_cmd", 32'(bus.o_Req_Cmd), 32'd0);
    check_eq("rst req_addr", 32'(bus.o_Req_Addr), 32'd0);
    check_eq("rst busy", 32'(bus.o_Busy), 32'd0);
    check_eq("rst overrun", 32'(bus.o_Overrun), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Normal request/response with latency checks
    rx_byte(8'h03);
    rx_byte(8'h05);
    @(negedge clk);
    check_eq("t1 validate no req", 32'(bus.o_Req_Valid), 32'd0);
    check_eq("t1 busy", 32'(bus.o_Busy), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("t1 req", 32'(bus.o_Req_Valid), 32'd1);
    check_eq("t1 cmd", 32'(bus.o_Req_Cmd), 32'h03);
    check_eq("t1 addr", 32'(bus.o_Req_Addr), 32'd5);
    next_cycle();
    @(negedge clk);
    check_eq("t1 req one cycle", 32'(bus.o_Req_Valid), 32'd0);
    repeat (3) next_cycle();
    e = cyc + 1;
    rsp(8'h08, 8'h2A);
    expect_rsp("t1", 8'h08, 8'h2A, 5, at0);
    check_eq("t1 rsp lat", at0, e);

    // Validation errors
    snap_req = n_req;
    rx_byte(8'h09);
    rx_byte(8'h01);
    e = cyc + 1;
    expect_rsp("t2 badcmd", 8'hFF, 8'h09, 5, at0);
    check_eq("t2 badcmd lat", at0, e);
    rx_byte(8'h02);
    rx_byte(8'h40);
    expect_rsp("t2 badaddr", 8'hFE, 8'h40, 5, at0);
    rx_byte(8'h80);
    rx_byte(8'h80);
    expect_rsp("t2 both bad", 8'hFF, 8'h80, 5, at0);
    check_eq("t2 no req", n_req, snap_req);
    check_eq("t2 cmd held", 32'(bus.o_Req_Cmd), 32'h03);
    do_req("t2 max", 8'h06, 8'h1F);
    rsp(8'h00, 8'h55);
    expect_rsp("t2 max", 8'h00, 8'h55, 5, at0);

    // Byte timeout: silent discard
    snap_dv  = n_dv;
    snap_req = n_req;
    rx_byte(8'h01);
    repeat (ByteTo - 1) next_cycle();
    @(negedge clk);
    check_eq("t4 busy before expiry", 32'(bus.o_Busy), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("t4 idle after expiry", 32'(bus.o_Busy), 32'd0);
    check_eq("t4 no tx", n_dv, snap_dv);
    check_eq("t4 no req", n_req, snap_req);
    next_cycle();
    // Byte 1 in the expiry cycle is accepted
    rx_byte(8'h05);
    repeat (ByteTo - 1) next_cycle();
    rx_byte(8'h06);
    next_cycle();
    @(negedge clk);
    check_eq("t4 edge req", 32'(bus.o_Req_Valid), 32'd1);
    check_eq("t4 edge cmd", 32'(bus.o_Req_Cmd), 32'h05);
    check_eq("t4 edge addr", 32'(bus.o_Req_Addr), 32'd6);
    next_cycle();
    rsp(8'h11, 8'h22);
    expect_rsp("t4 edge", 8'h11, 8'h22, 5, at0);
    do_req("t4 next", 8'h04, 8'h07);
    rsp(8'h00, 8'h11);
    expect_rsp("t4 next", 8'h00, 8'h11, 5, at0);

    // Response timeout, then a late response is ignored
    do_req("t5", 8'h01, 8'h02);
    w = cyc;
    expect_rsp("t5", 8'hFD, 8'h00, 40, at0);
    check_eq("t5 timeout lat", at0, w + RspTo);
    snap_dv = n_dv;
    rsp(8'h12, 8'h34);
    repeat (5) next_cycle();
    @(negedge clk);
    check_eq("t5 late busy", 32'(bus.o_Busy), 32'd0);
    check_eq("t5 late no tx", n_dv, snap_dv);
    next_cycle();
    // Response in the expiry cycle wins
    do_req("t5b", 8'h02, 8'h03);
    w = cyc;
    repeat (RspTo - 1) next_cycle();
    rsp(8'h44, 8'h55);
    expect_rsp("t5b", 8'h44, 8'h55, 5, at0);
    check_eq("t5b lat", at0, w + RspTo);

    // Overrun during WAIT_RSP and a stalled transmitter
    do_req("t6", 8'h03, 8'h04);
    rx_byte(8'h55);
    @(negedge clk);
    check_eq("t6 overrun", 32'(bus.o_Overrun), 32'd1);
    next_cycle();
    bus.i_Tx_Active = 1'b1;
    rsp(8'h01, 8'h99);
    snap_dv = n_dv;
    repeat (20) next_cycle();
    @(negedge clk);
    check_eq("t6 dv held off", n_dv, snap_dv);
    check_eq("t6 dv low", 32'(bus.o_Tx_DV), 32'd0);
    next_cycle();
    bus.i_Tx_Active = 1'b0;
    e = cyc;
    expect_rsp("t6", 8'h01, 8'h99, 3, at0);
    check_eq("t6 dv on active fall", at0, e);
    check_eq("t6 overrun sticky", 32'(bus.o_Overrun), 32'd1);

    // Reset during WAIT0 abandons the response
    do_req("t7", 8'h01, 8'h03);
    rsp(8'h77, 8'h66);
    wait_tx("t7 st", 8'h77, 5, at0);
    next_cycle();
    bus.i_Tx_Active = 1'b1;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.i_Tx_Active = 1'b0;
    @(negedge clk);
    check_eq("t7 busy", 32'(bus.o_Busy), 32'd0);
    check_eq("t7 tx_dv", 32'(bus.o_Tx_DV), 32'd0);
    check_eq("t7 tx_byte", 32'(bus.o_Tx_Byte), 32'd0);
    check_eq("t7 req_cmd", 32'(bus.o_Req_Cmd), 32'd0);
    check_eq("t7 req_addr", 32'(bus.o_Req_Addr), 32'd0);
    check_eq("t7 overrun", 32'(bus.o_Overrun), 32'd0);
    snap_dv = n_dv;
    next_cycle();
    bus.i_Tx_Done = 1'b1;
    next_cycle();
    bus.i_Tx_Done = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    check_eq("t7 no byte1", n_dv, snap_dv);
    check_eq("t7 still idle", 32'(bus.o_Busy), 32'd0);
    next_cycle();
    do_req("t7 next", 8'h02, 8'h1A);
    rsp(8'h5A, 8'hA5);
    expect_rsp("t7 next", 8'h5A, 8'hA5, 5, at0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

FPGA-side request/response engine for the PC serial link: consumes the byte stream from `uart_rx`, frames it into 2-byte requests (command, address), issues one request to the sensor/IO logic, and returns a 2-byte response (status, data) through `uart_tx`. It answers the PC's initiator protocol and sits between the UART pair and the application logic. It replaces ad-hoc wiring of `o_Rx_Byte` straight to display logic.

## Interface
Parameters:
- `BYTE_TIMEOUT_CLKS`, default 520900. Maximum number of clocks between byte 0 and byte 1 of a request.
- `RSP_TIMEOUT_CLKS`, default 50000000. Maximum number of clocks to wait for the application response.

Ports:
- Clock and reset. One clock; reset is synchronous and active-high.
  - `i_Clock`  in  1  system clock.
  - `i_Reset`  in  1  synchronous reset, active-high.
- From `uart_rx`:
  - `i_Rx_DV`  in  1  one-cycle strobe; a received byte is valid.
  - `i_Rx_Byte`  in  8  received byte.
- To/from `uart_tx`:
  - `o_Tx_DV`  out  1  one-cycle strobe to start a transmission.
  - `o_Tx_Byte`  out  8  byte to transmit. Held stable from `o_Tx_DV` until `i_Tx_Done`.
  - `i_Tx_Active`  in  1  transmitter busy.
  - `i_Tx_Done`  in  1  one-cycle strobe; byte fully sent.
- Application side:
  - `o_Req_Valid`  out  1  one-cycle request strobe.
  - `o_Req_Cmd`  out  8  command of the request. Held until the next request.
  - `o_Req_Addr`  out  5  address of the request. Held until the next request.
  - `i_Rsp_Valid`  in  1  one-cycle response strobe.
  - `i_Rsp_Code`  in  8  status byte.
  - `i_Rsp_Data`  in  8  data byte.
- Status:
  - `o_Busy`  out  1  high in every state except IDLE.
  - `o_Overrun`  out  1  sticky. Set when an Rx byte arrives outside IDLE or GOT_CMD. Cleared only by reset.

## Operation
- Reset values: `o_Tx_DV`=0, `o_Tx_Byte`=0x00, `o_Req_Valid`=0, `o_Req_Cmd`=0x00, `o_Req_Addr`=0, `o_Busy`=0, `o_Overrun`=0, state IDLE. Both timers are cleared.
- States and transitions:
  - IDLE: `i_Rx_DV` latches the command byte, then go to GOT_CMD.
  - GOT_CMD: `i_Rx_DV` latches the address byte, then validate.
    - If `BYTE_TIMEOUT_CLKS` elapses first, discard the frame and return to IDLE silently.
  - Validation:
    - Command > 0x06: load response (0xFF, cmd) and go to SEND0.
    - Address byte > 0x1F: load response (0xFE, addr byte) and go to SEND0.
    - Both checks fail: the command check wins.
    - Otherwise go to REQ.
  - REQ: `o_Req_Valid`=1 for exactly one cycle, then go to WAIT_RSP.
  - WAIT_RSP: `i_Rsp_Valid` loads (`i_Rsp_Code`, `i_Rsp_Data`) and goes to SEND0.
    - If `RSP_TIMEOUT_CLKS` elapses first, load (0xFD, 0x00) and go to SEND0.
  - SEND0: when `i_Tx_Active`=0, pulse `o_Tx_DV` with the status byte, then go to WAIT0.
  - WAIT0: on `i_Tx_Done`, go to SEND1.
  - SEND1: same as SEND0, but sends the data byte, then goes to WAIT1.
  - WAIT1: on `i_Tx_Done`, go to IDLE.
- Ignored inputs:
  - `i_Rsp_Valid` outside WAIT_RSP is ignored.
  - `i_Tx_Done` outside WAIT0/WAIT1 is ignored.
- Rx bytes in REQ, WAIT_RSP or SEND*/WAIT* are dropped and set `o_Overrun`.
- Reset mid-frame or mid-transmit returns immediately to IDLE; the partial response is not resumed.

## Timing
- `i_Rx_DV` for byte 1 at cycle m: `o_Req_Valid` is high at cycle m+2 (m+1 validate, m+2 REQ).
  - Error responses instead give `o_Tx_DV` at m+2 if the transmitter is idle.
- `i_Rsp_Valid` at cycle k: `o_Tx_DV` at k+1 if `i_Tx_Active`=0. Otherwise it is delayed until the first cycle with `i_Tx_Active`=0.
- `i_Tx_Done` for byte 0 at cycle t: `o_Tx_DV` for byte 1 at t+1 (subject to `i_Tx_Active`=0).
- `i_Tx_Done` for byte 1 at t: `o_Busy`=0 at t+1. A new byte 0 is accepted at t+1.
- Timers:
  - Each timer is an up-counter of width `$clog2(N+1)`.
  - It clears on entry to its state and expires when count == N-1, i.e. N cycles in state.
  - `i_Rsp_Valid` in the expiry cycle wins over the timeout. Likewise, `i_Rx_DV` in the byte-timeout expiry cycle is accepted.

## Structure
- Shared package `uart_cmd_pkg`:
  - state encoding.
  - status constants `ST_BAD_CMD`=0xFF, `ST_BAD_ADDR`=0xFE, `ST_TIMEOUT`=0xFD.
  - `CMD_MAX`=0x06 and `ADDR_MAX`=0x1F.
- Sub-module `cycle_timer` (parameter N; ports: clear, enable, expired). Instantiated twice, once per timeout.
- Top-level integration instantiates this block between `uart_rx`/`uart_tx` and the application logic. `CLKS_PER_BIT`=5209 is unchanged.

## Test plan
- Rx bytes 0x03 then 0x05 → `o_Req_Valid` pulse with Cmd=0x03, Addr=5. Then `i_Rsp_Valid` with (0x08, 0x2A) → Tx bytes 0x08 then 0x2A, each `o_Tx_DV` one cycle after the previous `i_Tx_Done`.
- Rx 0x09, 0x01 → no request; Tx 0xFF, 0x09. Rx 0x02, 0x40 → Tx 0xFE, 0x40.
- Rx 0x01 only, then `BYTE_TIMEOUT_CLKS` idle cycles → no Tx, `o_Busy`=0. The next 2-byte frame is served normally.
- Valid request, no `i_Rsp_Valid` for `RSP_TIMEOUT_CLKS` → Tx 0xFD, 0x00. A late `i_Rsp_Valid` afterwards is ignored.
- Rx byte during WAIT_RSP → `o_Overrun`=1 and the response is unaffected. Hold `i_Tx_Active`=1 for 20 cycles at SEND0 → `o_Tx_DV` is delayed until Active falls.
- Assert `i_Reset` during WAIT0 → all outputs at reset values next cycle and no byte 1 is sent. The next frame is handled normally.
